m_mem_arbiter: RTL and testbench

//  Two-port arbiter sharing one synchronous single-port m_memory (4K x 32, 1-cycle read latency)

---
 rtl/m_mem_arbiter_pkg.sv | 13 +
 rtl/m_memarb_fair.sv | 34 +++
 rtl/m_mem_arbiter.sv | 79 +++++++
 tb/tb_m_mem_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/m_mem_arbiter_pkg.sv
// Shared definitions for the m_mem_arbiter slice: response-owner encoding and default widths.
package m_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } own_e;

    localparam int unsigned MEMARB_AW = 12;
    localparam int unsigned MEMARB_DW = 32;

endpackage

// File: rtl/m_memarb_fair.sv
// Fairness helper for m_mem_arbiter: counts D accepts while I waits and raises force_i
// once MAX_DSTREAK consecutive D grants have gone by.
module m_memarb_fair #(
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic w_clk,
    input  logic w_rst,
    input  logic w_ce,
    input  logic w_i_req,
    input  logic w_i_acc,
    input  logic w_d_acc,
    output logic w_force_i
);

    localparam int unsigned CW = $clog2(MAX_DSTREAK + 1);

    logic [CW-1:0] r_streak;

    assign w_force_i = w_i_req && (r_streak == CW'(MAX_DSTREAK));

    // Streak saturates; frozen while the clock enable is low.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_streak <= '0;
        end else if (w_ce) begin
            if (w_i_acc || !w_i_req) begin
                r_streak <= '0;
            end else if (w_d_acc && (r_streak != CW'(MAX_DSTREAK))) begin
                r_streak <= r_streak + 1'b1;
            end
        end
    end

endmodule

// File: rtl/m_mem_arbiter.sv
// Two-port (I fetch / D load-store) arbiter for one synchronous single-port memory.
// Define MEMARB_FAIRNESS_EN to bound I starvation under fixed D priority.
module m_mem_arbiter
    import m_mem_arbiter_pkg::*;
#(
    parameter int unsigned AW          = MEMARB_AW,
    parameter int unsigned DW          = MEMARB_DW,
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic          w_clk,
    input  logic          w_rst,
    input  logic          w_ce,
    input  logic          w_i_req,
    input  logic [AW-1:0] w_i_addr,
    output logic          w_i_gnt,
    output logic          w_i_rvalid,
    output logic [DW-1:0] w_i_rdata,
    input  logic          w_d_req,
    input  logic          w_d_we,
    input  logic [AW-1:0] w_d_addr,
    input  logic [DW-1:0] w_d_wdata,
    output logic          w_d_gnt,
    output logic          w_d_rvalid,
    output logic [DW-1:0] w_d_rdata,
    output logic [AW-1:0] w_mem_addr,
    output logic          w_mem_we,
    output logic [DW-1:0] w_mem_din,
    input  logic [DW-1:0] w_mem_dout
);

    own_e r_own;
    logic w_force_i;
    logic w_grant_en;

    assign w_grant_en = !w_rst && w_ce;

`ifdef MEMARB_FAIRNESS_EN
    m_memarb_fair #(
        .MAX_DSTREAK (MAX_DSTREAK)
    ) u_fair (
        .w_clk     (w_clk),
        .w_rst     (w_rst),
        .w_ce      (w_ce),
        .w_i_req   (w_i_req),
        .w_i_acc   (w_i_gnt),
        .w_d_acc   (w_d_gnt),
        .w_force_i (w_force_i)
    );
`else
    assign w_force_i = 1'b0;
`endif

    assign w_d_gnt = w_grant_en && w_d_req && !w_force_i;
    assign w_i_gnt = w_grant_en && w_i_req && (!w_d_req || w_force_i);

    assign w_mem_addr = w_d_gnt ? w_d_addr  : (w_i_gnt ? w_i_addr : '0);
    assign w_mem_we   = w_d_gnt && w_d_we;
    assign w_mem_din  = w_d_gnt ? w_d_wdata : '0;

    // Response pipe runs regardless of w_ce so an accepted read always returns next cycle.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_own <= OWN_NONE;
        end else if (w_i_gnt) begin
            r_own <= OWN_I;
        end else if (w_d_gnt && !w_d_we) begin
            r_own <= OWN_D;
        end else begin
            r_own <= OWN_NONE;
        end
    end

    // A read still in flight when reset arrives is dropped rather than delivered.
    assign w_i_rvalid = (r_own == OWN_I) && !w_rst;
    assign w_d_rvalid = (r_own == OWN_D) && !w_rst;
    assign w_i_rdata  = w_mem_dout;
    assign w_d_rdata  = w_mem_dout;

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Directed bench for m_mem_arbiter with a behavioural 4K x 32 synchronous memory.
`timescale 1ns/1ps
module tb_m_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          w_clk = 1'b0;
    logic          w_rst;
    logic          w_ce;
    logic          w_i_req;
    logic [AW-1:0] w_i_addr;
    logic          w_i_gnt;
    logic          w_i_rvalid;
    logic [DW-1:0] w_i_rdata;
    logic          w_d_req;
    logic          w_d_we;
    logic [AW-1:0] w_d_addr;
    logic [DW-1:0] w_d_wdata;
    logic          w_d_gnt;
    logic          w_d_rvalid;
    logic [DW-1:0] w_d_rdata;
    logic [AW-1:0] w_mem_addr;
    logic          w_mem_we;
    logic [DW-1:0] w_mem_din;
    logic [DW-1:0] w_mem_dout;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_chk = 0;
    int n_err = 0;

    always #5 w_clk = ~w_clk;

    always @(posedge w_clk) begin
        if (w_mem_we) mem[w_mem_addr] <= w_mem_din;
        w_mem_dout <= mem[w_mem_addr];
    end

    m_mem_arbiter #(.AW(AW), .DW(DW), .MAX_DSTREAK(4)) dut (
        .w_clk      (w_clk),
        .w_rst      (w_rst),
        .w_ce       (w_ce),
        .w_i_req    (w_i_req),
        .w_i_addr   (w_i_addr),
        .w_i_gnt    (w_i_gnt),
        .w_i_rvalid (w_i_rvalid),
        .w_i_rdata  (w_i_rdata),
        .w_d_req    (w_d_req),
        .w_d_we     (w_d_we),
        .w_d_addr   (w_d_addr),
        .w_d_wdata  (w_d_wdata),
        .w_d_gnt    (w_d_gnt),
        .w_d_rvalid (w_d_rvalid),
        .w_d_rdata  (w_d_rdata),
        .w_mem_addr (w_mem_addr),
        .w_mem_we   (w_mem_we),
        .w_mem_din  (w_mem_din),
        .w_mem_dout (w_mem_dout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Each cycle window opens 2ns after the rising edge; inputs change there.
    task automatic cyc();
        @(posedge w_clk);
        #2;
    endtask

    initial begin
        logic exp_i, prev_i, prev_d;
        for (int a = 0; a < (1<<AW); a++) mem[a] = '0;
        mem[12'h010] = 32'h0000_0013;
        w_rst = 1'b1; w_ce = 1'b1;
        w_i_req = 1'b0; w_i_addr = '0;
        w_d_req = 1'b0; w_d_we = 1'b0; w_d_addr = '0; w_d_wdata = '0;

        // 1: reset held with both requests high
        for (int k = 0; k < 3; k++) begin
            cyc();
            w_i_req = 1'b1; w_d_req = 1'b1;
            #1;
            chk("rst_i_gnt", 32'(w_i_gnt), 0);
            chk("rst_d_gnt", 32'(w_d_gnt), 0);
            chk("rst_mem_we", 32'(w_mem_we), 0);
            chk("rst_mem_addr", 32'(w_mem_addr), 0);
            chk("rst_rvalid", {30'd0, w_i_rvalid, w_d_rvalid}, 0);
        end
        cyc(); w_rst = 1'b0; #1;
        chk("rel_d_gnt", 32'(w_d_gnt), 1);
        chk("rel_i_gnt", 32'(w_i_gnt), 0);
        cyc(); w_i_req = 1'b0; w_d_req = 1'b0; #1;
        chk("rel_d_rvalid", 32'(w_d_rvalid), 1);
        chk("rel_d_rdata", w_d_rdata, 32'h0);
        chk("rel_i_rvalid", 32'(w_i_rvalid), 0);

        // 2: I-only read
        cyc(); w_i_req = 1'b1; w_i_addr = 12'h010; #1;
        chk("i_gnt", 32'(w_i_gnt), 1);
        chk("i_mem_addr", 32'(w_mem_addr), 32'h010);
        chk("i_mem_we", 32'(w_mem_we), 0);
        cyc(); w_i_req = 1'b0; #1;
        chk("i_rvalid", 32'(w_i_rvalid), 1);
        chk("i_rdata", w_i_rdata, 32'h0000_0013);
        chk("i_no_d_rvalid", 32'(w_d_rvalid), 0);
        cyc(); #1;
        chk("i_rvalid_1cyc", 32'(w_i_rvalid), 0);

        // 3: write then read same address
        cyc(); w_d_req = 1'b1; w_d_we = 1'b1; w_d_addr = 12'h123; w_d_wdata = 32'hDEAD_BEEF; #1;
        chk("wr_d_gnt", 32'(w_d_gnt), 1);
        chk("wr_mem_we", 32'(w_mem_we), 1);
        chk("wr_mem_addr", 32'(w_mem_addr), 32'h123);
        chk("wr_mem_din", w_mem_din, 32'hDEAD_BEEF);
        cyc(); w_d_we = 1'b0; #1;
        chk("rd_d_gnt", 32'(w_d_gnt), 1);
        chk("rd_mem_we", 32'(w_mem_we), 0);
        chk("wr_no_rvalid", 32'(w_d_rvalid), 0);
        cyc(); w_d_req = 1'b0; #1;
        chk("raw_rvalid", 32'(w_d_rvalid), 1);
        chk("raw_rdata", w_d_rdata, 32'hDEAD_BEEF);

        // 4: both requesting for 20 cycles
        prev_i = 1'b0; prev_d = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            w_i_req = 1'b1; w_i_addr = 12'h010;
            w_d_req = 1'b1; w_d_we = 1'b0; w_d_addr = 12'h123;
            #1;
`ifdef MEMARB_FAIRNESS_EN
            exp_i = ((k % 5) == 4);
`else
            exp_i = 1'b0;
`endif
            chk($sformatf("both_i_gnt[%0d]", k), 32'(w_i_gnt), 32'(exp_i));
            chk($sformatf("both_d_gnt[%0d]", k), 32'(w_d_gnt), 32'(!exp_i));
            chk($sformatf("both_i_rv[%0d]", k), 32'(w_i_rvalid), 32'(prev_i));
            chk($sformatf("both_d_rv[%0d]", k), 32'(w_d_rvalid), 32'(prev_d));
            if (prev_i) chk($sformatf("both_i_data[%0d]", k), w_i_rdata, 32'h0000_0013);
            if (prev_d) chk($sformatf("both_d_data[%0d]", k), w_d_rdata, 32'hDEAD_BEEF);
            prev_i = exp_i; prev_d = !exp_i;
        end
        cyc(); w_i_req = 1'b0; w_d_req = 1'b0; #1;
        chk("both_tail_d_rv", 32'(w_d_rvalid), 32'(prev_d));

        // 5: clock enable low right after a read accept
        cyc(); w_d_req = 1'b1; w_d_we = 1'b0; w_d_addr = 12'h123; #1;
        chk("ce_d_gnt", 32'(w_d_gnt), 1);
        cyc(); w_ce = 1'b0; w_i_req = 1'b1; #1;
        chk("ce0_gnts", {30'd0, w_i_gnt, w_d_gnt}, 0);
        chk("ce0_d_rvalid", 32'(w_d_rvalid), 1);
        chk("ce0_d_rdata", w_d_rdata, 32'hDEAD_BEEF);
        cyc(); #1;
        chk("ce0_gnts2", {30'd0, w_i_gnt, w_d_gnt}, 0);
        chk("ce0_rvalid2", {30'd0, w_i_rvalid, w_d_rvalid}, 0);
        cyc(); w_ce = 1'b1; #1;
        chk("ce1_d_gnt", 32'(w_d_gnt), 1);
        cyc(); w_d_req = 1'b0; w_i_req = 1'b0; #1;
        chk("ce1_d_rvalid", 32'(w_d_rvalid), 1);

        // 6: reset the cycle after a D read accept
        cyc(); w_d_req = 1'b1; w_d_addr = 12'h123; #1;
        chk("r6_d_gnt", 32'(w_d_gnt), 1);
        cyc(); w_rst = 1'b1; w_d_req = 1'b0; #1;
        chk("r6_d_rvalid_in_rst", 32'(w_d_rvalid), 0);
        chk("r6_gnt_in_rst", 32'(w_d_gnt), 0);
        cyc(); w_rst = 1'b0; #1;
        chk("r6_d_rvalid_after", 32'(w_d_rvalid), 0);
        chk("r6_mem_we", 32'(w_mem_we), 0);
        chk("r6_mem_addr", 32'(w_mem_addr), 0);
`ifdef MEMARB_FAIRNESS_EN
        // Streak restarts from zero: four D grants before the first forced I grant.
        for (int k = 0; k < 5; k++) begin
            cyc(); w_i_req = 1'b1; w_d_req = 1'b1; #1;
            chk($sformatf("r6_streak_i[%0d]", k), 32'(w_i_gnt), 32'(k == 4));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
